// File: rtl/csa_pipe_adder.sv
// Pipelined carry-select adder/subtractor with valid/ready handshakes on both sides.
// Define CSA_OVF_EN to enable the signed-overflow output; otherwise ovf is tied low.
module csa_pipe_adder #(
    parameter int WIDTH            = 16,
    parameter int BLOCK            = 4,
    parameter int BLOCKS_PER_STAGE = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int unsigned NB = WIDTH / BLOCK;
    localparam int unsigned S  = (NB + BLOCKS_PER_STAGE - 1) / BLOCKS_PER_STAGE;

    logic             adv;
    logic [WIDTH-1:0] b_eff;
    logic             c0;
    logic [S-1:0]     v;
    logic [S-1:0]     carry;

    assign adv       = !v[S-1] || out_ready;
    assign in_ready  = adv;
    assign out_valid = v[S-1];
    assign b_eff     = sub ? ~b : b;
    assign c0        = sub | cin;
    assign cout      = carry[S-1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v <= '0;
        end else if (adv) begin
            v[0] <= in_valid && in_ready;
            for (int unsigned i = 1; i < S; i++) begin
                v[i] <= v[i-1];
            end
        end
    end

    for (genvar j = 0; j < S; j++) begin : g_stage
        localparam int unsigned LO    = j * BLOCKS_PER_STAGE * BLOCK;
        localparam int unsigned NBJ   = (NB - j * BLOCKS_PER_STAGE < BLOCKS_PER_STAGE) ?
                                        NB - j * BLOCKS_PER_STAGE : BLOCKS_PER_STAGE;
        localparam int unsigned W     = NBJ * BLOCK;
        localparam int unsigned DEPTH = S - j;

        logic [W-1:0]   op_a;
        logic [W-1:0]   op_b;
        logic [W-1:0]   res;
        logic           c_in;
        logic           c_out;
        logic           c_run;
        logic           c_q;
        logic [BLOCK:0] s0;
        logic [BLOCK:0] s1;
        logic [BLOCK:0] pick;
        logic [W-1:0]   s_d [DEPTH];

        if (j == 0) begin : g_head
            assign op_a = a[LO +: W];
            assign op_b = b_eff[LO +: W];
            assign c_in = c0;
        end else begin : g_skew
            // Slice is delayed j cycles so it meets stage j-1's carry for the same transaction.
            logic [W-1:0] a_d [j];
            logic [W-1:0] b_d [j];

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    for (int unsigned i = 0; i < j; i++) begin
                        a_d[i] <= '0;
                        b_d[i] <= '0;
                    end
                end else if (adv) begin
                    a_d[0] <= a[LO +: W];
                    b_d[0] <= b_eff[LO +: W];
                    for (int unsigned i = 1; i < j; i++) begin
                        a_d[i] <= a_d[i-1];
                        b_d[i] <= b_d[i-1];
                    end
                end
            end

            assign op_a = a_d[j-1];
            assign op_b = b_d[j-1];
            assign c_in = carry[j-1];
        end

        always_comb begin
            s0    = '0;
            s1    = '0;
            pick  = '0;
            res   = '0;
            c_run = c_in;
            for (int unsigned i = 0; i < NBJ; i++) begin
                s0    = {1'b0, op_a[i*BLOCK +: BLOCK]} + {1'b0, op_b[i*BLOCK +: BLOCK]};
                s1    = {1'b0, op_a[i*BLOCK +: BLOCK]} + {1'b0, op_b[i*BLOCK +: BLOCK]}
                        + {{BLOCK{1'b0}}, 1'b1};
                pick  = c_run ? s1 : s0;
                res[i*BLOCK +: BLOCK] = pick[BLOCK-1:0];
                c_run = pick[BLOCK];
            end
            c_out = c_run;
        end

        // Resolved slice rides a DEPTH-long delay line so all slices exit together.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                c_q <= 1'b0;
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    s_d[i] <= '0;
                end
            end else if (adv) begin
                c_q    <= c_out;
                s_d[0] <= res;
                for (int unsigned i = 1; i < DEPTH; i++) begin
                    s_d[i] <= s_d[i-1];
                end
            end
        end

        assign carry[j]     = c_q;
        assign sum[LO +: W] = s_d[DEPTH-1];
    end

`ifdef CSA_OVF_EN
    logic [S-1:0] sign_a;
    logic [S-1:0] sign_b;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sign_a <= '0;
            sign_b <= '0;
        end else if (adv) begin
            sign_a[0] <= a[WIDTH-1];
            sign_b[0] <= b_eff[WIDTH-1];
            for (int unsigned i = 1; i < S; i++) begin
                sign_a[i] <= sign_a[i-1];
                sign_b[i] <= sign_b[i-1];
            end
        end
    end

    assign ovf = (sign_a[S-1] == sign_b[S-1]) && (sum[WIDTH-1] != sign_a[S-1]);
`else
    assign ovf = 1'b0;
`endif

endmodule
